// File: rtl/brdg_interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// brdg_interrupt_arbiter
//
// Shares the bridge's single interrupt-request engine among NUM_REQ
// requesters. Enabled pending requests are arbitrated round-robin; the winner's
// 64-bit source is latched and presented to the engine with a level
// interrupt/interrupt_src handshake. Once the engine's acknowledge has risen
// and fallen again, the winner receives a one-cycle req_ack. A watchdog flags
// an engine acknowledge that does not arrive within timeout_limit cycles.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_mask        per-requester enable (1 = eligible)
//   req_valid       level request, held until the requester's req_ack pulse
//   req_src         NUM_REQ x 64-bit sources, requester i at [64*i +: 64]
//   req_ack         one-cycle completion pulse to the granted requester
//   interrupt       level request to the interrupt engine
//   interrupt_src   latched source of the granted requester
//   interrupt_ack   engine acknowledge level (success or failure)
//   grant_id        index of the current/last granted requester
//   busy            high whenever a transaction is in flight
//   timeout_limit   watchdog limit in cycles, 0 disables
//   timeout_err     sticky watchdog flag
//   err_clr         clears timeout_err (a simultaneous set wins)
// -----------------------------------------------------------------------------
module brdg_interrupt_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_mask,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*64-1:0]  req_src,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   interrupt,
  output logic [63:0]            interrupt_src,
  input  logic                   interrupt_ack,
  output logic [2:0]             grant_id,
  output logic                   busy,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RELEASE  = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  state_t               state;
  logic [2:0]           rr_ptr;
  logic [TIMEOUT_W-1:0] wd_cnt;

  // Saturating increment: the watchdog counter never wraps back to zero.
  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (&v) ? v : v + TIMEOUT_W'(1);
  endfunction

  // Requests and sources are zero-padded to the 8-requester maximum so the
  // 3-bit selection indexes them directly for any legal NUM_REQ.
  logic [7:0]           elig8;
  logic [511:0]         src8;
  logic                 found;
  logic [2:0]           sel;
  logic [2:0]           rr_next;
  logic [NUM_REQ-1:0]   ack_vec;
  logic                 wd_hit;

  assign src8 = 512'(req_src);

  // First eligible requester at or after rr_ptr, searching cyclically upward.
  always_comb begin
    int idx;
    elig8 = 8'(req_valid & req_mask);
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!found && elig8[3'(idx)]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  always_comb begin
    int nx;
    nx = int'(grant_id) + 1;
    if (nx >= NUM_REQ) nx = 0;
    rr_next = 3'(nx);
  end

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) ack_vec[i] = (grant_id == 3'(i));
  end

  assign wd_hit = (state == WAIT_ACK) && (timeout_limit != '0) && (wd_cnt == timeout_limit);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      interrupt     <= 1'b0;
      interrupt_src <= '0;
      grant_id      <= '0;
      req_ack       <= '0;
      rr_ptr        <= '0;
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id      <= sel;
            interrupt_src <= src8[{sel, 6'b0} +: 64];
            interrupt     <= 1'b1;
            wd_cnt        <= '0;
            state         <= WAIT_ACK;
          end
        end
        // The request is committed from here on; requester inputs are ignored.
        WAIT_ACK: begin
          wd_cnt <= sat_inc(wd_cnt);
          if (interrupt_ack) begin
            interrupt <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!interrupt_ack) begin
            req_ack <= ack_vec;
            rr_ptr  <= rr_next;
            state   <= HOLDOFF;
          end
        end
        // Gives the acknowledged requester one cycle to drop req_valid.
        HOLDOFF: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (wd_hit)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_brdg_interrupt_arbiter.sv
module tb_brdg_interrupt_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_mask;
  logic [3:0]    req_valid;
  logic [255:0]  req_src;
  logic [3:0]    req_ack;
  logic          interrupt;
  logic [63:0]   interrupt_src;
  logic          interrupt_ack;
  logic [2:0]    grant_id;
  logic          busy;
  logic [19:0]   timeout_limit;
  logic          timeout_err;
  logic          err_clr;

  logic [63:0]   src [4];
  assign req_src = {src[3], src[2], src[1], src[0]};

  int n_assert = 0;
  int n_fail   = 0;
  int rr_m     = 0;     // reference round-robin pointer
  logic exp_err = 1'b0; // reference timeout_err

  brdg_interrupt_arbiter #(.NUM_REQ(4), .TIMEOUT_W(20)) dut (
    .clk(clk), .rst(rst), .req_mask(req_mask), .req_valid(req_valid),
    .req_src(req_src), .req_ack(req_ack), .interrupt(interrupt),
    .interrupt_src(interrupt_src), .interrupt_ack(interrupt_ack),
    .grant_id(grant_id), .busy(busy), .timeout_limit(timeout_limit),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first eligible index at or after ptr, cyclically.
  function automatic int pick(input logic [3:0] elig, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (ptr + k) % 4;
      if (elig[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // One transaction seen from the engine side. Offsets are cycles after the
  // first cycle with interrupt=1 (offset 0). The engine raises its ack at
  // offset lag for hold cycles. mask1/vclr1 are applied at offset 1,
  // err_clr is pulsed at offset clr_at (-1 = never).
  task automatic txn(input bit immediate, input int lag, input int hold,
                     input logic [3:0] mask1, input logic [3:0] vclr1,
                     input int clr_at, input bit auto_drop);
    int waited;
    int id;
    int a;
    int r;
    logic [1:0] id2;
    logic [3:0] oh;
    logic set;
    @(negedge clk);
    waited = 1;
    while (interrupt !== 1'b1 && waited < 40) begin
      chk("idle_req_ack", 64'(req_ack), 64'd0);
      @(negedge clk);
      waited++;
    end
    chk("interrupt_rise", 64'(interrupt), 64'd1);
    if (interrupt !== 1'b1) return;
    if (immediate) chk("grant_latency", 64'(waited), 64'd1);
    id = pick(req_valid & req_mask, rr_m);
    if (id < 0) id = 0;
    id2 = id[1:0];
    oh  = 4'b0001 << id2;
    chk("grant_id", 64'(grant_id), 64'(id));
    chk("interrupt_src", interrupt_src, src[id2]);
    a = lag;
    r = lag + hold;
    for (int o = 0; o <= r + 2; o++) begin
      if (o > 0) @(negedge clk);
      chk("interrupt", 64'(interrupt), 64'(o <= a));
      chk("req_ack", 64'(req_ack), (o == r + 1) ? 64'(oh) : 64'd0);
      chk("busy", 64'(busy), 64'(o <= r + 1));
      chk("timeout_err", 64'(timeout_err), 64'(exp_err));
      interrupt_ack = (o >= a) && (o < a + hold);
      err_clr       = (o == clr_at);
      if (o == 1) begin
        req_mask  = mask1;
        req_valid = req_valid & ~vclr1;
      end
      if (o == r + 1 && auto_drop) req_valid = req_valid & ~oh;
      set = (timeout_limit != 0) && (o == int'(timeout_limit)) && (o <= a);
      exp_err = set ? 1'b1 : (err_clr ? 1'b0 : exp_err);
    end
    err_clr = 1'b0;
    chk("grant_id_hold", 64'(grant_id), 64'(id));
    rr_m = (id + 1) % 4;
  endtask

  initial begin
    int w;
    rst = 1'b1; req_mask = '0; req_valid = '0; interrupt_ack = 1'b0;
    timeout_limit = '0; err_clr = 1'b0;
    for (int i = 0; i < 4; i++) src[i] = 64'h1111_0000_0000_0000 * (i + 1) + 64'(i);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_interrupt", 64'(interrupt), 64'd0);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_src", interrupt_src, 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    rst = 1'b0;

    // Single request, engine acks 3 cycles after interrupt for 1 cycle
    src[0] = 64'hDEAD_BEEF; req_mask = 4'b1111; req_valid = 4'b0001;
    txn(1'b1, 3, 1, 4'b1111, 4'b0000, -1, 1'b1);

    // Round robin from a fresh pointer: 0,1,2,3,0
    rst = 1'b1; @(negedge clk); rst = 1'b0; rr_m = 0;
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) txn(1'b1, 1 + t, 1 + (t % 2), 4'b1111, 4'b0000, -1, 1'b0);
    req_valid = 4'b0000;

    // Mask: only requester 1, then unmask 3 mid-transaction
    req_valid = 4'b1010; req_mask = 4'b0010;
    txn(1'b1, 2, 1, 4'b1010, 4'b0000, -1, 1'b1);
    txn(1'b1, 1, 2, 4'b1010, 4'b0000, -1, 1'b1);

    // Withdrawal: requester 2 drops req_valid one cycle after grant
    src[2] = 64'h0123_4567_89AB_CDEF; req_mask = 4'b1111; req_valid = 4'b0100;
    txn(1'b1, 2, 1, 4'b1111, 4'b0100, -1, 1'b1);

    // Watchdog: limit 16, late ack, then clear, then clear vs new timeout
    timeout_limit = 20'd16; req_valid = 4'b0001;
    txn(1'b1, 25, 1, 4'b1111, 4'b0000, -1, 1'b1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; exp_err = 1'b0;
    chk("err_clr", 64'(timeout_err), 64'd0);
    req_valid = 4'b0001;
    txn(1'b1, 22, 1, 4'b1111, 4'b0000, 16, 1'b1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; exp_err = 1'b0;
    chk("err_clr2", 64'(timeout_err), 64'd0);
    timeout_limit = '0;

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          src[i] = {$urandom, $urandom};
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == 4'b0000) begin
        src[0] = {$urandom, $urandom};
        req_valid[0] = 1'b1;
      end
      req_mask = 4'($urandom_range(0, 15));
      if ((req_valid & req_mask) == 4'b0000) req_mask = req_mask | req_valid;
      txn(1'b1, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
          req_mask, 4'b0000, -1, 1'b1);
    end

    // Reset in WAIT_ACK
    req_mask = 4'b1111; req_valid = 4'b0010;
    w = 0;
    @(negedge clk);
    while (interrupt !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    chk("pre_reset_interrupt", 64'(interrupt), 64'd1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("mid_rst_interrupt", 64'(interrupt), 64'd0);
    chk("mid_rst_req_ack", 64'(req_ack), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rr_m = 0; exp_err = 1'b0;
    req_valid = 4'b0011;
    txn(1'b1, 2, 1, 4'b1111, 4'b0000, -1, 1'b1);
    txn(1'b1, 0, 1, 4'b1111, 4'b0000, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
